gpio_port: RTL
==============

GPIO_PORT -- requirements
Module: gpio_port

Parameters
REQ-001 SHALL have parameter WIDTH, default 32: data/address bus width.
REQ-002 SHALL have parameter N_GPIO, default 8: pin count, range 1..WIDTH.

Interface
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 addr  input  WIDTH  byte address from core; only addr[4:2] decoded.
REQ-006 wdata  input  WIDTH  write data.
REQ-007 we_gpio  input  1  write strobe from bus_interconnect; GPIO region already selected.
REQ-008 rdata_gpio  output  WIDTH  registered read data to bus_interconnect.
REQ-009 gpio_in  input  N_GPIO  asynchronous pin inputs.
REQ-010 gpio_out  output  N_GPIO  pin output values (OUT register).
REQ-011 gpio_oe  output  N_GPIO  pin output enables (DIR register, 1 = drive).
REQ-012 irq  output  1  interrupt request, level, active-high.

Function
REQ-013 SHALL decode addr[4:2]: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 IE (RW), 4 IP (RW1C); codes 5-7 read 0, writes ignored.
REQ-014 Write SHALL take effect at the rising edge where we_gpio=1; register visible on outputs the following cycle.
REQ-015 Writes SHALL use wdata[N_GPIO-1:0]; upper bits ignored; writes to IN ignored.
REQ-016 rdata_gpio SHALL be registered every cycle (one-cycle read latency): value for addr at edge k present after edge k; bits above N_GPIO SHALL read 0.
REQ-017 Read of a register in the same cycle as a write to it SHALL return the pre-write value.
REQ-018 gpio_in SHALL pass a 2-FF synchronizer (sync1, sync2); IN = sync2; change at pin before edge k visible in IN after edge k+1.
REQ-019 Rising-edge detect per bit: rise = sync2 & ~prev, prev <= sync2 every cycle; IP bit set at the edge following rise, regardless of IE and DIR.
REQ-020 IP write SHALL clear bits where wdata=1, leave bits where wdata=0.
REQ-021 Simultaneous set (rise) and W1C clear on same bit SHALL leave bit set (set wins).
REQ-022 irq SHALL equal OR-reduction of (IP & IE), combinational from registers; enabling IE on an already pending bit asserts irq the cycle after the IE write.
REQ-023 gpio_out = OUT, gpio_oe = DIR, driven directly from registers.
REQ-024 No other bus state; block SHALL accept back-to-back writes every cycle.

Reset
REQ-025 While rst=1 at a rising edge: OUT, DIR, IE, IP, sync1, sync2, prev, rdata_gpio SHALL load 0; irq=0, gpio_out=0, gpio_oe=0 after that edge.
REQ-026 rst SHALL dominate we_gpio and edge detection in the same cycle.
REQ-027 A pin held high across reset release SHALL be treated as a rising edge: IP bit set 3 edges after rst deasserts (sync1, sync2, IP).
REQ-028 Reset mid-operation SHALL discard any in-flight write or edge; no partial update.

Verification
REQ-029 Reset, write addr=0x0 wdata=0x000000A5, then addr=0x4 wdata=0x0000000F -> gpio_out=0xA5, gpio_oe=0x0F; read addr=0x0 one cycle later -> rdata_gpio=0x000000A5.
REQ-030 gpio_in 0x00->0x3C -> rdata_gpio for addr=0x8 reads 0x3C no earlier than 2 edges after change; IP=0x3C one edge later; irq stays 0 with IE=0.
REQ-031 IE=0x04, IP=0x3C -> irq=1; write addr=0x10 wdata=0x04 -> IP=0x38, irq=0 next cycle.
REQ-032 Rise on bit 0 in same cycle as W1C write 0x01 to IP -> IP[0]=1 after edge.
REQ-033 Write wdata=0xFFFFFFFF to addr=0x0 with N_GPIO=8 -> readback 0x000000FF; read addr=0x14 -> 0; write addr=0x8 -> IN unchanged.
REQ-034 Assert rst for one cycle with OUT=0xA5, IE=0xFF, IP=0x0F, gpio_in=0x01 -> all outputs 0 after edge; IP=0x01 3 edges after release.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO block with output, direction, input,
// interrupt-enable and W1C interrupt-pending registers. Pin inputs are
// brought into the clock domain through a two-flop synchronizer, and every
// synchronized rising edge latches a pending bit.
module gpio_port #(
  parameter int WIDTH  = 32,
  parameter int N_GPIO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              we_gpio,
  output logic [WIDTH-1:0]  rdata_gpio,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  // Register map, decoded from the word offset addr[4:2].
  typedef enum logic [2:0] {
    REG_OUT = 3'd0,
    REG_DIR = 3'd1,
    REG_IN  = 3'd2,
    REG_IE  = 3'd3,
    REG_IP  = 3'd4
  } reg_sel_e;

  logic [N_GPIO-1:0] r_out;
  logic [N_GPIO-1:0] r_dir;
  logic [N_GPIO-1:0] r_ie;
  logic [N_GPIO-1:0] r_ip;
  logic [N_GPIO-1:0] r_sync1;
  logic [N_GPIO-1:0] r_sync2;
  logic [N_GPIO-1:0] r_prev;
  logic [WIDTH-1:0]  r_rdata;

  logic [2:0]        w_sel;
  logic [N_GPIO-1:0] w_wdata;
  logic              w_we_out;
  logic              w_we_dir;
  logic              w_we_ie;
  logic              w_we_ip;
  logic [N_GPIO-1:0] w_ip_clr;
  logic [N_GPIO-1:0] w_rise;
  logic [WIDTH-1:0]  w_rd_val;
  logic              w_unused_bits;

  assign w_sel   = addr[4:2];
  assign w_wdata = wdata[N_GPIO-1:0];

  // Only the word offset is decoded; the rest of addr and the upper wdata
  // bits are intentionally ignored. Folding them here keeps lint quiet.
  assign w_unused_bits = ^{addr[WIDTH-1:5], addr[1:0], wdata};

  // Per-register write strobes. IN and the unmapped codes 5-7 get none.
  assign w_we_out = we_gpio && (w_sel == REG_OUT);
  assign w_we_dir = we_gpio && (w_sel == REG_DIR);
  assign w_we_ie  = we_gpio && (w_sel == REG_IE);
  assign w_we_ip  = we_gpio && (w_sel == REG_IP);

  // Bits to clear in IP: only the ones written as 1 during an IP write.
  assign w_ip_clr = w_we_ip ? w_wdata : '0;

  // Synchronized rising edge: high now, low one cycle ago.
  assign w_rise = r_sync2 & ~r_prev;

  // Two-flop synchronizer plus edge-history flop for the pin inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples its pre-edge source value; blocking here would
    // collapse the synchronizer into a single stage.
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Software-written control registers: OUT, DIR, IE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_dir <= '0;
      r_ie  <= '0;
    end else begin
      if (w_we_out) r_out <= w_wdata;
      if (w_we_dir) r_dir <= w_wdata;
      if (w_we_ie)  r_ie  <= w_wdata;
    end
  end

  // Interrupt-pending: W1C clear first, then OR in new edges so a set in
  // the same cycle as a clear on that bit leaves it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ip <= '0;
    end else begin
      r_ip <= (r_ip & ~w_ip_clr) | w_rise;
    end
  end

  // Read mux over current register contents (pre-write values); bits above
  // N_GPIO and unmapped offsets read as zero.
  always_comb begin
    // NOTE: default assigned first so every path drives w_rd_val and no
    // latch is inferred for the unmapped offsets or the upper bits.
    w_rd_val = '0;
    case (w_sel)
      REG_OUT: w_rd_val[N_GPIO-1:0] = r_out;
      REG_DIR: w_rd_val[N_GPIO-1:0] = r_dir;
      REG_IN:  w_rd_val[N_GPIO-1:0] = r_sync2;
      REG_IE:  w_rd_val[N_GPIO-1:0] = r_ie;
      REG_IP:  w_rd_val[N_GPIO-1:0] = r_ip;
      default: w_rd_val = '0;
    endcase
  end

  // Read data is registered every cycle, giving a fixed one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_val;
    end
  end

  assign rdata_gpio = r_rdata;
  assign gpio_out   = r_out;
  assign gpio_oe    = r_dir;
  assign irq        = |(r_ip & r_ie);

endmodule
